// File: rtl/serial_frame_tx.sv
// Framed serialiser feeding the 4-stage shift chain: start(1), WIDTH data bits LSB first,
// optional parity, stop(0). A one-word holding buffer lets frames run back to back.
module serial_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int ODD       = 0
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             busy,
  output logic             frame_done,
  output logic [2:0]       dbg_state
);

  // Handshake: a word moves on the falling CLK edge where in_valid && in_ready are both high;
  // in_valid may drop at any time and in_data is don't-care whenever no transfer happens.

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int         CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic       ODD_BIT = (ODD != 0);

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [WIDTH-1:0] hold, hold_d;
  logic             hold_full, hold_full_d;
  logic             par, par_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             sout_d;
  logic             accept, take_direct;

  assign in_ready    = ~hold_full & ~RES;
  assign accept      = in_valid & in_ready;
  // A word bypasses the buffer only when the shifter is free at this very edge.
  assign take_direct = accept & ((state == IDLE) | (state == STOP));
  assign busy        = (state != IDLE);
  assign frame_done  = (state == STOP);
  assign dbg_state   = state;

  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    hold_d      = hold;
    hold_full_d = hold_full;
    par_d       = par;
    cnt_d       = cnt;
    if (accept && !take_direct) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
    case (state)
      IDLE: begin
        if (take_direct) begin
          state_d = START;
          shreg_d = in_data;
          par_d   = (^in_data) ^ ODD_BIT;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt == LAST) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          cnt_d   = cnt + 1'b1;
          shreg_d = shreg >> 1;
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
        // Parity is taken from the word as it enters the shifter, never from shifted bits.
        if (hold_full) begin
          state_d     = START;
          shreg_d     = hold;
          par_d       = (^hold) ^ ODD_BIT;
          hold_full_d = 1'b0;
        end else if (take_direct) begin
          state_d = START;
          shreg_d = in_data;
          par_d   = (^in_data) ^ ODD_BIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   sout_d = 1'b1;
      DATA:    sout_d = shreg_d[0];
      PARITY:  sout_d = par_d;
      default: sout_d = 1'b0;
    endcase
  end

  // Falling-edge flops to line up with the downstream shift chain.
  always_ff @(negedge CLK or posedge RES) begin
    if (RES) begin
      state     <= IDLE;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      par       <= 1'b0;
      cnt       <= '0;
      sout      <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      par       <= par_d;
      cnt       <= cnt_d;
      sout      <= sout_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three parameter variants, directed and random words checked
// against frame streams built from the framing rules, plus a 4-stage loopback chain.
module tb_serial_frame_tx;

  logic       CLK;
  logic       RES;
  logic [7:0] in_data;
  logic [2:0] vld;
  logic [2:0] rdy_w, sout_w, busy_w, fd_w;
  logic [2:0] dbg0, dbg1, dbg2;

  int checks = 0;
  int errors = 0;

  int pen_a [3] = '{1, 1, 0};
  int odd_a [3] = '{0, 1, 0};

  logic [1:0] exp_q[$];   // {frame_done, sout} per cycle
  logic [7:0] words_q[$];
  logic       hist[$];
  logic [3:0] chain;
  int         low_rdy;

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .ODD(0)) u_even (
    .CLK(CLK), .RES(RES), .in_data(in_data), .in_valid(vld[0]), .in_ready(rdy_w[0]),
    .sout(sout_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]), .dbg_state(dbg0));
  serial_frame_tx #(.WIDTH(8), .PARITY_EN(1), .ODD(1)) u_odd (
    .CLK(CLK), .RES(RES), .in_data(in_data), .in_valid(vld[1]), .in_ready(rdy_w[1]),
    .sout(sout_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]), .dbg_state(dbg1));
  serial_frame_tx #(.WIDTH(8), .PARITY_EN(0), .ODD(0)) u_nopar (
    .CLK(CLK), .RES(RES), .in_data(in_data), .in_valid(vld[2]), .in_ready(rdy_w[2]),
    .sout(sout_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]), .dbg_state(dbg2));

  // downstream 4-stage shift chain fed by the even-parity instance
  always_ff @(negedge CLK or posedge RES) begin
    if (RES) chain <= '0;
    else     chain <= {chain[2:0], sout_w[0]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: the cycle-by-cycle line image of one frame
  task automatic push_frame(input logic [7:0] w, input int pen, input int odd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(w[i]);
    exp_q.push_back(2'b01);
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, w[i]});
    if (pen != 0) exp_q.push_back({1'b0, ((ones % 2) != odd)});
    exp_q.push_back(2'b10);
  endtask

  task automatic loop_step();
    hist.push_back(sout_w[0]);
    check("loop_so", 32'(chain[3]), 32'(hist[hist.size()-5]));
  endtask

  // driver: offers words_q back to back on one instance and checks every line cycle.
  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_stream(input string tag, input int inst, input bit loop_chk);
    int  wi = 0;
    int  cyc = 0;
    bit  started = 1'b0;
    logic [1:0] e;
    exp_q.delete();
    foreach (words_q[i]) push_frame(words_q[i], pen_a[inst], odd_a[inst]);
    low_rdy = 0;
    while ((exp_q.size() > 0 || !started) && cyc < 400) begin
      if (wi < words_q.size()) begin
        vld[inst] = 1'b1;
        in_data   = words_q[wi];
      end else begin
        vld[inst] = 1'b0;
        in_data   = 8'($urandom);
      end
      if (vld[inst] && rdy_w[inst]) begin
        wi++;
        started = 1'b1;
      end
      @(posedge CLK);
      cyc++;
      if (loop_chk) loop_step();
      if (started && exp_q.size() > 0) begin
        if (!rdy_w[inst]) low_rdy++;
        e = exp_q.pop_front();
        check({tag, "_sout"}, 32'(sout_w[inst]), 32'(e[0]));
        check({tag, "_fd"},   32'(fd_w[inst]),   32'(e[1]));
        check({tag, "_busy"}, 32'(busy_w[inst]), 32'd1);
      end
    end
    check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
    vld[inst] = 1'b0;
    @(posedge CLK);
    if (loop_chk) loop_step();
    check({tag, "_idle_sout"}, 32'(sout_w[inst]), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy_w[inst]), 32'd0);
    check({tag, "_idle_fd"},   32'(fd_w[inst]),   32'd0);
    check({tag, "_idle_rdy"},  32'(rdy_w[inst]),  32'd1);
  endtask

  initial begin
    // 1: reset with valid asserted
    RES = 1'b1;
    vld = 3'b111;
    in_data = 8'($urandom);
    repeat (2) @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      check("rst_sout", 32'(sout_w[i]), 32'd0);
      check("rst_busy", 32'(busy_w[i]), 32'd0);
      check("rst_rdy",  32'(rdy_w[i]),  32'd0);
      check("rst_fd",   32'(fd_w[i]),   32'd0);
    end
    RES = 1'b0;
    vld = 3'b000;
    repeat (3) begin
      @(posedge CLK);
      check("rel_rdy",  32'(rdy_w[0]),  32'd1);
      check("rel_sout", 32'(sout_w[0]), 32'd0);
      check("rel_busy", 32'(busy_w[0]), 32'd0);
    end

    // 2: single word, even parity
    words_q = '{8'hA5};
    run_stream("a5", 0, 1'b0);

    // 3: back to back; ready stays low from buffer load to the first STOP exit
    words_q = '{8'h01, 8'h80};
    run_stream("b2b", 0, 1'b0);
    check("b2b_low_rdy", 32'(low_rdy), 32'd10);

    // 4: parity variants
    words_q = '{8'hFF};
    run_stream("odd_ff", 1, 1'b0);
    words_q = '{8'h07};
    run_stream("even_07", 0, 1'b0);
    words_q = '{8'hA5};
    run_stream("nopar_a5", 2, 1'b0);

    // 5: reset during data bit 3 with a word buffered
    vld[0] = 1'b1;
    in_data = 8'hA8;
    @(posedge CLK);
    in_data = 8'h99;
    @(posedge CLK);
    vld[0] = 1'b0;
    repeat (3) @(posedge CLK);
    check("mid_bit3", 32'(sout_w[0]), 32'd1);
    check("mid_rdy",  32'(rdy_w[0]),  32'd0);
    RES = 1'b1;
    #1;
    check("abort_sout", 32'(sout_w[0]), 32'd0);
    check("abort_busy", 32'(busy_w[0]), 32'd0);
    check("abort_fd",   32'(fd_w[0]),   32'd0);
    check("abort_rdy",  32'(rdy_w[0]),  32'd0);
    repeat (2) @(posedge CLK);
    RES = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      check("post_sout", 32'(sout_w[0]), 32'd0);
      check("post_busy", 32'(busy_w[0]), 32'd0);
      check("post_fd",   32'(fd_w[0]),   32'd0);
    end
    words_q = '{8'h3C};
    run_stream("after_rst", 0, 1'b0);

    // 6: loopback through the shift chain
    repeat (5) @(posedge CLK);
    hist = '{1'b0, 1'b0, 1'b0, 1'b0};
    words_q = '{8'hA5, 8'h5A};
    run_stream("loop", 0, 1'b1);
    repeat (5) begin
      @(posedge CLK);
      loop_step();
    end

    // random back-to-back words on every variant
    for (int k = 0; k < 3; k++) begin
      repeat (2) begin
        words_q.delete();
        repeat (3) words_q.push_back(8'($urandom_range(0, 255)));
        run_stream("rand", k, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
